color_grid_store: RTL and testbench
===================================

Name: color_grid_store

Overview:
- Parametrised colour-cell store for the VGA display path: a grid of 2^ROW_W x 2^COL_W cells, each COLOR_W bits wide.
- Written from board switches and a pushbutton strobe. Read by the VGA timing block through cell-select coordinates HCS/VCS.
- Compared with the fixed 8x8x3 store, this block adds:
  - a synchronised, edge-detected write strobe;
  - a clear-all sweep triggered by a button, with a selectable fill colour;
  - automatic clear to 0 after reset;
  - a registered pixel output with a BUSY flag.

Parameters:
COL_W, 3, column address width (2^COL_W columns)
ROW_W, 3, row address width (2^ROW_W rows)
COLOR_W, 3, bits per cell (bit0=R, bit1=G, bit2=B for the default)

Ports:
CLOCK_50  in  1  system clock
RESET_N  in  1  asynchronous active-low reset
WR_N  in  1  raw write pushbutton, active-low, asynchronous to CLOCK_50
WR_ROW  in  ROW_W  write row address
WR_COL  in  COL_W  write column address
WR_COLOR  in  COLOR_W  write data
CLR_N  in  1  raw clear pushbutton, active-low, asynchronous
CLR_COLOR  in  COLOR_W  fill colour for button-triggered clear
HCS  in  COL_W  read column select
VCS  in  ROW_W  read row select
PIX  out  COLOR_W  registered cell colour at (VCS,HCS)
BUSY  out  1  high while a clear sweep runs
WR_ACK  out  1  one-cycle pulse when a write commits

Behaviour:
- Reset (RESET_N low, asynchronous):
  - PIX=0, WR_ACK=0, BUSY=1.
  - Synchronisers are set to 1 (button released). Sweep index=0. FSM enters INIT_CLR.
  - The array itself is not reset asynchronously.
- Input synchronisation:
  - WR_N and CLR_N each pass through a 2-FF synchroniser, then a previous-value register.
  - A falling edge is detected when the synchronised value is 0 and the previous value is 1.
  - Result: one event per press, committed at the 3rd rising edge after the low level is first sampled.
  - A button held low produces no further events.
- FSM states:
  - INIT_CLR: sweep writes 0 to cells in row-major order, index 0..N-1 with N=2^(ROW_W+COL_W), one cell per cycle. When the index reaches N-1, the FSM goes to IDLE on the next edge.
  - IDLE: BUSY=0.
    - A write event writes WR_COLOR to [WR_ROW][WR_COL] on the commit edge and pulses WR_ACK high for the following cycle.
    - A clear event latches CLR_COLOR, resets the index to 0 and moves the FSM to CLEAR.
  - CLEAR: same sweep as INIT_CLR, using the latched colour; returns to IDLE after index N-1.
- Clear-sweep common rules (INIT_CLR and CLEAR):
  - BUSY=1 throughout; an INIT_CLR or CLEAR sweep takes exactly N cycles.
  - Write events are dropped: no array change, no WR_ACK.
  - A clear event during CLEAR is ignored; the sweep is not restarted.
- Simultaneous write and clear events in IDLE: clear wins, write is dropped, no WR_ACK.
- Address/data sampling: WR_ROW, WR_COL and WR_COLOR are sampled on the commit edge only. CLR_COLOR is sampled on the clear-event edge only; later changes do not affect a running sweep.
- Read path:
  - PIX <= array[VCS][HCS] every cycle; one-cycle latency from HCS/VCS.
  - Reads stay active during sweeps and show the partially cleared contents.
  - Same-cell write and read in the same cycle: PIX shows the old value that cycle and the new value the next cycle (read-before-write).
- Index width: ROW_W+COL_W bits. Upper bits form the row, lower bits the column. No wrap beyond N-1.
- Reset asserted mid-sweep or mid-synchronisation: all state is abandoned and INIT_CLR restarts from index 0 after release.

Test Plan:
- Reset release with default parameters:
  - BUSY=1 for exactly 64 cycles, then 0.
  - Reading all 64 cells afterwards gives PIX=0.
  - WR_ACK stays 0 throughout.
- Write press: WR_ROW=5, WR_COL=2, WR_COLOR=3'b101, WR_N low for 10 cycles.
  - Exactly one WR_ACK pulse, at the 3rd edge after WR_N is first sampled low.
  - With VCS=5, HCS=2, PIX=3'b101 one cycle after the commit.
  - Neighbouring cells remain 0.
- Clear press with CLR_COLOR=3'b011, then CLR_COLOR changed to 3'b111 mid-sweep:
  - BUSY high for 64 cycles.
  - All cells read 3'b011 afterwards.
- Write press during CLEAR: no WR_ACK, and the target cell holds the clear colour after the sweep. A clear press during CLEAR does not extend BUSY beyond 64 cycles.
- Simultaneous WR_N and CLR_N falling in the same cycle in IDLE:
  - Sweep starts, no WR_ACK.
  - Cell [WR_ROW][WR_COL] ends at CLR_COLOR.
- RESET_N pulsed low at sweep index 20:
  - PIX=0 and BUSY=1 immediately.
  - After release, BUSY lasts a full 64 cycles and every cell reads 0.
- Same-cell read during write (VCS/HCS at the write address):
  - PIX shows the old value on the commit cycle and the new value on the next cycle.

Source files
------------

// File: rtl/color_grid_store.sv
// Colour-cell grid for the VGA path: button-driven writes and fill sweeps,
// automatic clear after reset, registered pixel read-out at (VCS,HCS).
module color_grid_store #(
  parameter int COL_W   = 3,
  parameter int ROW_W   = 3,
  parameter int COLOR_W = 3
) (
  input  logic               CLOCK_50,
  input  logic               RESET_N,
  input  logic               WR_N,
  input  logic [ROW_W-1:0]   WR_ROW,
  input  logic [COL_W-1:0]   WR_COL,
  input  logic [COLOR_W-1:0] WR_COLOR,
  input  logic               CLR_N,
  input  logic [COLOR_W-1:0] CLR_COLOR,
  input  logic [COL_W-1:0]   HCS,
  input  logic [ROW_W-1:0]   VCS,
  output logic [COLOR_W-1:0] PIX,
  output logic               BUSY,
  output logic               WR_ACK
);

  localparam int IDX_W = ROW_W + COL_W;
  localparam int N     = 1 << IDX_W;

  typedef enum logic [1:0] {
    S_INIT_CLR,
    S_IDLE,
    S_CLEAR
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [IDX_W-1:0]     r_idx, w_idx_nxt;
  logic [COLOR_W-1:0]   r_clr_color, w_clr_color_nxt;
  logic                 r_ack, w_ack_nxt;
  logic [COLOR_W-1:0]   r_pix;

  logic                 r_wr_s1, r_wr_s2, r_wr_prev;
  logic                 r_clr_s1, r_clr_s2, r_clr_prev;
  logic                 w_wr_ev, w_clr_ev;

  logic                 w_we;
  logic [IDX_W-1:0]     w_waddr;
  logic [COLOR_W-1:0]   w_wdata;

  logic [COLOR_W-1:0]   r_mem [N];

  // Synchronisers idle high (button released) so reset never fakes a press
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_wr_s1    <= 1'b1;
      r_wr_s2    <= 1'b1;
      r_wr_prev  <= 1'b1;
      r_clr_s1   <= 1'b1;
      r_clr_s2   <= 1'b1;
      r_clr_prev <= 1'b1;
    end else begin
      r_wr_s1    <= WR_N;
      r_wr_s2    <= r_wr_s1;
      r_wr_prev  <= r_wr_s2;
      r_clr_s1   <= CLR_N;
      r_clr_s2   <= r_clr_s1;
      r_clr_prev <= r_clr_s2;
    end
  end

  assign w_wr_ev  = ~r_wr_s2  & r_wr_prev;
  assign w_clr_ev = ~r_clr_s2 & r_clr_prev;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= S_INIT_CLR;
      r_idx       <= '0;
      r_clr_color <= '0;
      r_ack       <= 1'b0;
      r_pix       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_clr_color <= w_clr_color_nxt;
      r_ack       <= w_ack_nxt;
      r_pix       <= r_mem[{VCS, HCS}];
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_clr_color_nxt = r_clr_color;
    w_ack_nxt       = 1'b0;
    w_we            = 1'b0;
    w_waddr         = r_idx;
    w_wdata         = '0;
    case (r_state)
      S_INIT_CLR, S_CLEAR: begin
        w_we    = 1'b1;
        w_wdata = (r_state == S_CLEAR) ? r_clr_color : '0;
        if (r_idx == '1) w_state_nxt = S_IDLE;
        else             w_idx_nxt   = r_idx + 1'b1;
      end
      S_IDLE: begin
        // Clear outranks a coincident write; the write is simply lost
        if (w_clr_ev) begin
          w_clr_color_nxt = CLR_COLOR;
          w_idx_nxt       = '0;
          w_state_nxt     = S_CLEAR;
        end else if (w_wr_ev) begin
          w_we      = 1'b1;
          w_waddr   = {WR_ROW, WR_COL};
          w_wdata   = WR_COLOR;
          w_ack_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_INIT_CLR;
        w_idx_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  assign PIX    = r_pix;
  assign WR_ACK = r_ack;
  assign BUSY   = (r_state != S_IDLE);

endmodule

// File: tb/tb_color_grid_store.sv
// Bench for color_grid_store: reference grid model plus a queue of expected
// pixel values that is drained as the registered read path produces them.
module tb_color_grid_store;

  localparam int COL_W   = 3;
  localparam int ROW_W   = 3;
  localparam int COLOR_W = 3;
  localparam int NCELL   = 64;

  logic               CLOCK_50 = 1'b0;
  logic               RESET_N;
  logic               WR_N;
  logic [ROW_W-1:0]   WR_ROW;
  logic [COL_W-1:0]   WR_COL;
  logic [COLOR_W-1:0] WR_COLOR;
  logic               CLR_N;
  logic [COLOR_W-1:0] CLR_COLOR;
  logic [COL_W-1:0]   HCS;
  logic [ROW_W-1:0]   VCS;
  logic [COLOR_W-1:0] PIX;
  logic               BUSY;
  logic               WR_ACK;

  int total = 0;
  int bad   = 0;
  int ack_cnt = 0;

  logic [COLOR_W-1:0] exp_mem [NCELL];
  logic [COLOR_W-1:0] sb [$];

  color_grid_store #(
    .COL_W   (COL_W),
    .ROW_W   (ROW_W),
    .COLOR_W (COLOR_W)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .RESET_N   (RESET_N),
    .WR_N      (WR_N),
    .WR_ROW    (WR_ROW),
    .WR_COL    (WR_COL),
    .WR_COLOR  (WR_COLOR),
    .CLR_N     (CLR_N),
    .CLR_COLOR (CLR_COLOR),
    .HCS       (HCS),
    .VCS       (VCS),
    .PIX       (PIX),
    .BUSY      (BUSY),
    .WR_ACK    (WR_ACK)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(negedge CLOCK_50) if (WR_ACK === 1'b1) ack_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic fill(input logic [COLOR_W-1:0] c);
    for (int i = 0; i < NCELL; i++) exp_mem[i] = c;
  endtask

  task automatic rd(input int r, input int c);
    logic [COLOR_W-1:0] e;
    @(negedge CLOCK_50);
    VCS = r[ROW_W-1:0];
    HCS = c[COL_W-1:0];
    sb.push_back(exp_mem[r*8 + c]);
    step();
    e = sb.pop_front();
    chk("pix", PIX, e);
  endtask

  task automatic rd_all();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) rd(r, c);
  endtask

  // BUSY cycles from a reset release made at a falling clock edge
  task automatic busy_after_release(output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (BUSY && cnt < 200);
  endtask

  task automatic wait_rise(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      step();
      if (BUSY) ok = 1'b1;
    end
  endtask

  // Called right after BUSY was first seen high
  task automatic count_busy(output int cnt);
    cnt = 1;
    forever begin
      step();
      if (!BUSY || cnt >= 200) break;
      cnt++;
    end
  endtask

  initial begin
    int   c;
    int   a0;
    logic ok;

    RESET_N = 1'b0; WR_N = 1'b1; CLR_N = 1'b1;
    WR_ROW = '0; WR_COL = '0; WR_COLOR = '0; CLR_COLOR = '0;
    HCS = '0; VCS = '0;

    // Reset and automatic clear
    repeat (3) step();
    chk("rst_pix", PIX, 0);
    chk("rst_busy", BUSY, 1);
    chk("rst_ack", WR_ACK, 0);
    @(negedge CLOCK_50) RESET_N = 1'b1;
    busy_after_release(c);
    chk("init_busy_len", c, 64);
    fill('0);
    rd_all();
    chk("init_no_ack", ack_cnt, 0);

    // Single write press, read at the same cell across the commit
    @(negedge CLOCK_50);
    WR_ROW = 3'd5; WR_COL = 3'd2; WR_COLOR = 3'b101;
    VCS = 3'd5; HCS = 3'd2;
    a0 = ack_cnt;
    WR_N = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      sb.push_back((k <= 3) ? exp_mem[42] : 3'b101);
      step();
      chk("wr_ack_timing", WR_ACK, (k == 3) ? 1 : 0);
      chk("rbw_pix", PIX, sb.pop_front());
    end
    exp_mem[42] = 3'b101;
    repeat (6) @(negedge CLOCK_50);
    WR_N = 1'b1;
    repeat (5) step();
    chk("wr_ack_once", ack_cnt - a0, 1);
    rd(5, 2); rd(5, 1); rd(5, 3); rd(4, 2); rd(6, 2);

    // Clear with colour change mid-sweep
    @(negedge CLOCK_50);
    CLR_COLOR = 3'b011; CLR_N = 1'b0;
    wait_rise(ok);
    chk("clr_rise", ok, 1);
    fork
      count_busy(c);
      begin
        repeat (10) @(negedge CLOCK_50);
        CLR_COLOR = 3'b111; CLR_N = 1'b1;
      end
    join
    chk("clr_busy_len", c, 64);
    fill(3'b011);
    rd_all();

    // Write and second clear pressed during a running sweep
    @(negedge CLOCK_50);
    CLR_COLOR = 3'b110; CLR_N = 1'b0;
    wait_rise(ok);
    chk("clr2_rise", ok, 1);
    a0 = ack_cnt;
    fork
      count_busy(c);
      begin
        @(negedge CLOCK_50) CLR_N = 1'b1;
        repeat (5) @(negedge CLOCK_50);
        WR_ROW = 3'd2; WR_COL = 3'd7; WR_COLOR = 3'b001;
        WR_N = 1'b0; CLR_N = 1'b0;
        repeat (6) @(negedge CLOCK_50);
        WR_N = 1'b1; CLR_N = 1'b1;
      end
    join
    chk("clr2_busy_len", c, 64);
    repeat (5) step();
    chk("clr2_no_ack", ack_cnt - a0, 0);
    chk("clr2_idle", BUSY, 0);
    fill(3'b110);
    rd(2, 7); rd(0, 0); rd(7, 7);

    // Simultaneous write and clear presses in IDLE
    @(negedge CLOCK_50);
    WR_ROW = 3'd1; WR_COL = 3'd1; WR_COLOR = 3'b010; CLR_COLOR = 3'b100;
    a0 = ack_cnt;
    WR_N = 1'b0; CLR_N = 1'b0;
    wait_rise(ok);
    chk("sim_rise", ok, 1);
    fork
      count_busy(c);
      begin
        repeat (4) @(negedge CLOCK_50);
        WR_N = 1'b1; CLR_N = 1'b1;
      end
    join
    chk("sim_busy_len", c, 64);
    chk("sim_no_ack", ack_cnt - a0, 0);
    fill(3'b100);
    rd(1, 1); rd(1, 2);

    // Reset pulsed at sweep index 20
    @(negedge CLOCK_50);
    CLR_COLOR = 3'b101; CLR_N = 1'b0;
    VCS = 3'd5; HCS = 3'd0;
    wait_rise(ok);
    chk("rst2_rise", ok, 1);
    repeat (20) step();
    chk("pre_rst_pix", PIX, 3'b100);
    RESET_N = 1'b0;
    CLR_N = 1'b1;
    #1;
    chk("mid_rst_pix", PIX, 0);
    chk("mid_rst_busy", BUSY, 1);
    chk("mid_rst_ack", WR_ACK, 0);
    repeat (2) @(negedge CLOCK_50);
    @(negedge CLOCK_50) RESET_N = 1'b1;
    busy_after_release(c);
    chk("rst2_busy_len", c, 64);
    fill('0);
    rd_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
